mp_row_mul: RTL and testbench

Parametrised multi-precision row multiplier: computes one operand-by-digit product `a × b` for the Montgomery/modmul datapath, where `a` is a (SIZE+2)-bit operand and `b` is one RADIX-bit digit. The operand is split into RADIX-bit chunks and processed LANES chunks per pass over as many passes as needed. The result is returned in redundant carry-save form, `r0 + r1 == a × b`. It replaces the fixed 3-pass, 19-lane row multiplier with generic SIZE/RADIX/LANES, a valid/ready handshake on both sides and output hold under backpressure.

---
 rtl/mp_row_mul_pkg.sv | 19 +
 rtl/mp_row_mul_lane.sv | 12 +
 rtl/mp_row_mul.sv | 141 ++++++++++++++
 tb/tb_mp_row_mul.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mp_row_mul_pkg.sv
// Shared types and derived-size helpers for the multi-precision row multiplier.
package mp_row_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  // Operand is SIZE+2 bits wide, cut into RADIX-bit chunks.
  function automatic int calc_nchunk(input int size, input int radix);
    return ceil_div(size + 2, radix);
  endfunction

  function automatic int calc_passes(input int nchunk, input int lanes);
    return ceil_div(nchunk, lanes);
  endfunction

endpackage

// File: rtl/mp_row_mul_lane.sv
// Combinational RADIX x RADIX unsigned multiplier, one per lane; the parent registers the product.
module mp_lane_mul #(
  parameter int RADIX = 54
) (
  input  logic [RADIX-1:0]   a,
  input  logic [RADIX-1:0]   b,
  output logic [2*RADIX-1:0] p
);

  assign p = {{RADIX{1'b0}}, a} * {{RADIX{1'b0}}, b};

endmodule

// File: rtl/mp_row_mul.sv
// Operand-by-digit multiplier: r0 + r1 == a * b in carry-save form, LANES chunks per pass.
// Optional MP_ROW_MUL_ABORT_EN adds an abort input that drops RUN/DONE back to IDLE.
module mp_row_mul
  import mp_row_mul_pkg::*;
#(
  parameter int SIZE  = 3072,
  parameter int RADIX = 54,
  parameter int LANES = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SIZE+1:0]       a,
  input  logic [RADIX-1:0]      b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SIZE+RADIX+1:0] r0,
  output logic [SIZE+RADIX+1:0] r1
`ifdef MP_ROW_MUL_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  localparam int AW     = SIZE + 2;
  localparam int RW     = SIZE + RADIX + 2;
  localparam int NCHUNK = calc_nchunk(SIZE, RADIX);
  localparam int PASSES = calc_passes(NCHUNK, LANES);
  localparam int SLOTS  = PASSES * LANES;
  // One spare pass of zero padding keeps the idle-time lane select in range.
  localparam int PADW   = (SLOTS + LANES) * RADIX;
  // Internal result width covers every lane slot plus the carry shift; a guard bit keeps the drop-slice non-empty.
  localparam int EW     = (SLOTS + 1) * RADIX + 1;
  localparam int CW     = $clog2(PASSES + 1);

  state_t state_q, state_d;

  logic [AW-1:0]      a_q;
  logic [RADIX-1:0]   b_q;
  logic [PADW-1:0]    a_pad;
  logic [CW-1:0]      pass_q;
  logic [CW-1:0]      wb_pass;
  logic               wb_vld;
  logic [EW-1:0]      r0_q, r1_q;
  logic [2*RADIX-1:0] prod_q [LANES];
  logic [RADIX-1:0]   lane_a [LANES];
  logic [2*RADIX-1:0] lane_p [LANES];
  logic               abort_req;
  logic               issue_done;
  logic               unused_bits;

`ifdef MP_ROW_MUL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign issue_done = (pass_q == CW'(PASSES));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (abort_req)                 state_d = IDLE;
        else if (issue_done && !wb_vld) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort_req || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_pad         = '0;
    a_pad[AW-1:0] = a_q;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_a[k] = a_pad[RADIX*(int'(pass_q)*LANES + k) +: RADIX];
    mp_lane_mul #(.RADIX(RADIX)) u_mul (
      .a (lane_a[k]),
      .b (b_q),
      .p (lane_p[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      pass_q  <= '0;
      wb_pass <= '0;
      wb_vld  <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else begin
      wb_vld <= 1'b0;
      if (state_q == IDLE && in_valid) begin
        a_q    <= a;
        b_q    <= b;
        r0_q   <= '0;
        r1_q   <= '0;
        pass_q <= '0;
      end else if (state_q == RUN && !abort_req) begin
        if (!issue_done) begin
          for (int k = 0; k < LANES; k++) prod_q[k] <= lane_p[k];
          wb_pass <= pass_q;
          wb_vld  <= 1'b1;
          pass_q  <= pass_q + CW'(1);
        end
        // Low half lands on the chunk, high half one chunk up in the carry vector.
        if (wb_vld) begin
          for (int k = 0; k < LANES; k++) begin
            r0_q[RADIX*(int'(wb_pass)*LANES + k)     +: RADIX] <= prod_q[k][RADIX-1:0];
            r1_q[RADIX*(int'(wb_pass)*LANES + k + 1) +: RADIX] <= prod_q[k][2*RADIX-1:RADIX];
          end
        end
      end
    end
  end

  assign r0 = r0_q[RW-1:0];
  assign r1 = r1_q[RW-1:0];
  assign unused_bits = ^{r0_q[EW-1:RW], r1_q[EW-1:RW]};

endmodule

// File: tb/tb_mp_row_mul.sv
// Bench for mp_row_mul: default-size instance and a SIZE=100/RADIX=16/LANES=2 instance vs. plain a*b.
module tb_mp_row_mul;

  localparam int BW  = 3074;
  localparam int BRW = 3128;
  localparam int SW  = 102;
  localparam int SRW = 118;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic           b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BW-1:0]  b_a;
  logic [53:0]    b_b;
  logic [BRW-1:0] b_r0, b_r1;

  logic           s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [SW-1:0]  s_a;
  logic [15:0]    s_b;
  logic [SRW-1:0] s_r0, s_r1;

`ifdef MP_ROW_MUL_ABORT_EN
  logic b_abort, s_abort;
`endif

  mp_row_mul u_big (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a), .b(b_b),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .r0(b_r0), .r1(b_r1)
`ifdef MP_ROW_MUL_ABORT_EN
    , .abort(b_abort)
`endif
  );

  mp_row_mul #(.SIZE(100), .RADIX(16), .LANES(2)) u_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .r0(s_r0), .r1(s_r1)
`ifdef MP_ROW_MUL_ABORT_EN
    , .abort(s_abort)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_big();
    logic [3103:0] t;
    for (int i = 0; i < 97; i++) t[i*32 +: 32] = $urandom;
    return t[BW-1:0];
  endfunction

  function automatic logic [SW-1:0] rand_small();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[SW-1:0];
  endfunction

  // Reference: the integer product, compared against the carry-save sum with one spare bit.
  task automatic big_check(input string tag, input logic [BW-1:0] av, input logic [53:0] bv);
    logic [BRW:0] s, p;
    s = {1'b0, b_r0} + {1'b0, b_r1};
    p = (BRW+1)'(av) * (BRW+1)'(bv);
    chk({tag, "_sum"}, 64'(s == p), 64'd1);
    chk({tag, "_lo"}, s[63:0], p[63:0]);
    chk({tag, "_r1lo"}, 64'(b_r1[53:0]), 64'd0);
  endtask

  task automatic big_start(input logic [BW-1:0] av, input logic [53:0] bv);
    chk("big_in_ready", 64'(b_in_ready), 64'd1);
    b_a = av; b_b = bv; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_a = rand_big(); b_b = 54'($urandom);
  endtask

  task automatic big_wait(output int n);
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic big_pop();
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("big_pop_ovld", 64'(b_out_valid), 64'd0);
    chk("big_pop_ird", 64'(b_in_ready), 64'd1);
  endtask

  task automatic big_op(input string tag, input logic [BW-1:0] av, input logic [53:0] bv);
    int n;
    big_start(av, bv);
    big_wait(n);
    chk({tag, "_lat"}, 64'(n), 64'd5);
    big_check(tag, av, bv);
    big_pop();
  endtask

  task automatic small_op(input logic [SW-1:0] av, input logic [15:0] bv);
    int n;
    logic [SRW:0] s, p;
    chk("sm_in_ready", 64'(s_in_ready), 64'd1);
    s_a = av; s_b = bv; s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_a = rand_small(); s_b = 16'($urandom);
    n = 0;
    while (!s_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sm_lat", 64'(n), 64'd6);
    s = {1'b0, s_r0} + {1'b0, s_r1};
    p = (SRW+1)'(av) * (SRW+1)'(bv);
    chk("sm_sum", 64'(s == p), 64'd1);
    chk("sm_r1lo", 64'(s_r1[15:0]), 64'd0);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("sm_pop_ird", 64'(s_in_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [BW-1:0] av;
    logic [53:0]   bv;
    logic [SW-1:0] sa;

    rst_n = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_a = '0; b_b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0;
`ifdef MP_ROW_MUL_ABORT_EN
    b_abort = 1'b0; s_abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovld", 64'(b_out_valid), 64'd0);
    chk("rst_ird", 64'(b_in_ready), 64'd1);
    chk("rst_r0", 64'(|b_r0), 64'd0);
    chk("rst_r1", 64'(|b_r1), 64'd0);
    chk("rst_sm_ovld", 64'(s_out_valid), 64'd0);
    chk("rst_sm_ird", 64'(s_in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // a = 1, b = 1
    big_start('d1, 54'd1);
    big_wait(n);
    chk("one_lat", 64'(n), 64'd5);
    chk("one_r0", 64'(b_r0 == BRW'(1)), 64'd1);
    chk("one_r1", 64'(|b_r1), 64'd0);
    big_pop();

    // All-ones operands, then 10 cycles of backpressure with ignored in_valid pulses
    av = '1; bv = '1;
    big_start(av, bv);
    big_wait(n);
    chk("ones_lat", 64'(n), 64'd5);
    chk("ones_r0lo", 64'(b_r0[53:0]), 64'd1);
    chk("ones_r1c1", 64'(b_r1[107:54]), 64'h003F_FFFF_FFFF_FFFE);
    big_check("ones", av, bv);
    for (int i = 0; i < 10; i++) begin
      b_in_valid = i[0];
      b_a = rand_big(); b_b = 54'($urandom);
      @(posedge clk); #1;
      chk("bp_ovld", 64'(b_out_valid), 64'd1);
      chk("bp_ird", 64'(b_in_ready), 64'd0);
      big_check("bp", av, bv);
    end
    b_in_valid = 1'b0;
    big_pop();

    // Reset sampled at E+2 in the middle of RUN
    big_start(rand_big(), 54'($urandom));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_ovld", 64'(b_out_valid), 64'd0);
    chk("mrst_r0", 64'(|b_r0), 64'd0);
    chk("mrst_r1", 64'(|b_r1), 64'd0);
    chk("mrst_ird", 64'(b_in_ready), 64'd1);
    big_op("after_rst", rand_big(), 54'($urandom));

    for (int i = 0; i < 6; i++) begin
      av = rand_big();
      bv = {$urandom, $urandom};
      if (i == 0) bv = '0;
      if (i == 1) av = '0;
      big_op("rnd", av, bv);
    end

`ifdef MP_ROW_MUL_ABORT_EN
    begin
      int seen;
      big_start(rand_big(), 54'($urandom));
      @(posedge clk); #1;
      @(posedge clk); #1;
      b_abort = 1'b1;
      @(posedge clk); #1;
      b_abort = 1'b0;
      chk("abort_ird", 64'(b_in_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (b_out_valid) seen++;
        @(posedge clk); #1;
      end
      chk("abort_ovld", 64'(seen), 64'd0);
      big_op("after_abort", rand_big(), 54'($urandom));
    end
`endif

    for (int i = 0; i < 1000; i++) begin
      sa = rand_small();
      if (i == 0) sa = '1;
      if (i == 1) sa = '0;
      small_op(sa, (i == 0) ? 16'hFFFF : 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
